mc_datapath: RTL
================

MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000: PC value loaded on reset.
REQ-002 Parameter HALT_ON_ILLEGAL, default 1: 1 = unsupported instruction enters HALT; 0 = retired as NOP.
REQ-003 Port clk  in  1: single clock; all state updates on rising edge.
REQ-004 Port reset  in  1: asynchronous, active-low reset.
REQ-005 Ports imem_req out 1, imem_addr out 32, imem_ready in 1, imem_rdata in 32: instruction fetch handshake.
REQ-006 Ports dmem_req out 1, dmem_we out 1, dmem_addr out 32, dmem_wdata out 32, dmem_ready in 1, dmem_rdata in 32: data handshake.
REQ-007 Ports retire out 1, retire_pc out 32: one-cycle pulse and PC of each completed instruction.
REQ-008 Ports wb_we out 1, wb_addr out 5, wb_data out 32: register-file write trace, valid when wb_we=1.
REQ-009 Port halted out 1: high while in HALT.

Function
REQ-010 Internal 32x32 register file; reads of $0 return 0; writes to $0 are discarded, with wb_we still pulsing.
REQ-011 Supported: addu(0/21), subu(0/23), sll(0/00), jr(0/08), ori(0d), lui(0f), lw(23), sw(2b), beq(04), j(02), jal(03); hex opcode/funct.
REQ-012 FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT; one state per cycle unless stalled by a handshake.
REQ-013 FETCH: imem_req=1, imem_addr=PC; IR latched and -> DECODE in the cycle imem_ready=1; otherwise stay.
REQ-014 imem_addr and dmem_addr/we/wdata are held stable while req=1; req deasserts in the cycle after ready is seen.
REQ-015 DECODE: latch A=GPR[rs], B=GPR[rt]; ext = zero-extend for ori, sign-extend otherwise; illegal -> HALT or WB-as-NOP per HALT_ON_ILLEGAL.
REQ-016 EXEC: ALU computes addu/subu/sll/ori/lui/address; 32-bit wrap, no overflow trap.
REQ-017 EXEC, beq: PC <= PC+4+(ext<<2) if A==B, else PC+4; retire; -> FETCH.
REQ-018 EXEC, j: PC <= {PC+4[31:28], index, 2'b00}; jr: PC <= A; both retire, -> FETCH.
REQ-019 EXEC, lw/sw -> MEM; all other instructions -> WB.
REQ-020 MEM: dmem_req=1, dmem_addr={sum[31:2],2'b00}, dmem_we=1 for sw with dmem_wdata=B; on dmem_ready, sw retires -> FETCH, lw latches dmem_rdata -> WB.
REQ-021 WB: write rd (R-type), rt (ori/lui/lw), or $31 with PC+4 (jal, also PC <= jump target); other PCs <= PC+4; retire; -> FETCH.
REQ-022 Zero-wait latency: beq/j/jr 3 cycles; R-type/ori/lui/jal/sw 4; lw 5; each wait cycle adds 1.
REQ-023 HALT: no requests, no retire, halted=1; left only by reset.
REQ-024 imem_ready or dmem_ready while the matching req=0 is ignored.

Reset
REQ-025 On reset low, immediately: PC=RESET_PC, state=FETCH, all GPRs=0, all req/we/retire/wb_we/halted=0, all address/data outputs=0.
REQ-026 Reset mid-handshake drops req in the same cycle; no partial write commits.
REQ-027 After reset release, imem_req=1 with imem_addr=RESET_PC on the first clock edge's cycle.

Verification
REQ-028 Zero-wait ori $1,$0,0x1234 then addu $2,$1,$1 -> wb (1,0x1234) then (2,0x2468); retire cycles 4 apart; retire_pc 0x3000, 0x3004.
REQ-029 sw $2,4($0) with dmem_ready delayed 3 cycles -> dmem_req/addr=0x4/wdata=0x2468 held stable 4 cycles; retire on handshake cycle.
REQ-030 lw $3,4($0) returning 0x2468 -> wb (3,0x2468) 5 cycles after fetch start; beq $3,$2,-1 taken -> next imem_addr = branch PC.
REQ-031 jal 0x3100 at 0x3010 -> wb (31,0x3014), next imem_addr 0x0000_3100 (index 0x0C40); jr $31 -> next fetch 0x3014.
REQ-032 ori $0,$0,5 -> wb_we=1 addr 0; later addu $4,$0,$0 writes 0.
REQ-033 Opcode 0x3f with HALT_ON_ILLEGAL=1 -> halted=1, no further req; reset low mid-FETCH -> outputs zero, refetch RESET_PC.

Source files
------------

// File: rtl/mc_datapath.sv
// mc_datapath: multi-cycle datapath for a small MIPS-style subset with
// request/ready handshakes on the instruction and data memory ports.
//
// state  | meaning
// FETCH  | imem_req high with imem_addr = PC; waits for imem_ready
// DECODE | register operands and immediate latched, legality decided
// EXEC   | ALU result; beq/j/jr resolve the PC and retire here
// MEM    | dmem_req high for lw/sw; waits for dmem_ready
// WB     | register-file write, PC <= PC+4 or jal target, retire
// HALT   | unsupported instruction seen; only reset leaves this state
module mc_datapath #(
    parameter logic [31:0] RESET_PC        = 32'h0000_3000,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        retire,
    output logic [31:0] retire_pc,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    state_t      state;
    logic [31:0] pc, ir, a, b, ext, alu, mdr;
    logic [31:0] gpr [32];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign shamt = ir[10:6];
    assign funct = ir[5:0];
    assign imm   = ir[15:0];

    logic        legal;
    logic        done;
    logic [31:0] pc4, br_target, j_target, alu_res, wb_val, next_pc;
    logic [4:0]  wb_dst;

    assign pc4       = pc + 32'd4;
    assign br_target = pc4 + {ext[29:0], 2'b00};
    assign j_target  = {pc4[31:28], ir[25:0], 2'b00};

    // supported opcode/funct combinations
    always_comb begin
        legal = 1'b0;
        case (op)
            OP_RTYPE: legal = (funct == FN_ADDU) || (funct == FN_SUBU) ||
                              (funct == FN_SLL)  || (funct == FN_JR);
            OP_J, OP_JAL, OP_BEQ, OP_ORI, OP_LUI, OP_LW, OP_SW: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    // ALU; lw/sw fall through to the address add
    always_comb begin
        alu_res = a + ext;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: alu_res = a + b;
                    FN_SUBU: alu_res = a - b;
                    FN_SLL:  alu_res = b << shamt;
                    default: alu_res = '0;
                endcase
            end
            OP_ORI:  alu_res = a | ext;
            OP_LUI:  alu_res = {imm, 16'h0000};
            default: alu_res = a + ext;
        endcase
    end

    // write-back destination and value
    always_comb begin
        wb_dst = rt;
        wb_val = alu;
        if (op == OP_RTYPE) begin
            wb_dst = rd;
        end else if (op == OP_JAL) begin
            wb_dst = 5'd31;
            wb_val = pc4;
        end else if (op == OP_LW) begin
            wb_val = mdr;
        end
    end

    // retirement point and the PC the next fetch uses
    always_comb begin
        done    = 1'b0;
        next_pc = pc4;
        case (state)
            S_EXEC: begin
                if (op == OP_BEQ) begin
                    done = 1'b1;
                    if (a == b) next_pc = br_target;
                end else if (op == OP_J) begin
                    done    = 1'b1;
                    next_pc = j_target;
                end else if (op == OP_RTYPE && funct == FN_JR) begin
                    done    = 1'b1;
                    next_pc = a;
                end
            end
            S_MEM: if (dmem_req && dmem_ready && op == OP_SW) done = 1'b1;
            S_WB: begin
                done = 1'b1;
                if (legal && op == OP_JAL) next_pc = j_target;
            end
            default: done = 1'b0;
        endcase
    end

    // control FSM, datapath registers, register file and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            ir         <= '0;
            a          <= '0;
            b          <= '0;
            ext        <= '0;
            alu        <= '0;
            mdr        <= '0;
            for (int i = 0; i < 32; i++) gpr[i] <= '0;
            imem_req   <= 1'b0;
            imem_addr  <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            retire     <= 1'b0;
            retire_pc  <= '0;
            wb_we      <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            halted     <= 1'b0;
        end else begin
            retire <= 1'b0;
            wb_we  <= 1'b0;
            case (state)
                S_FETCH: begin
                    // first cycle out of reset raises the request
                    if (!imem_req) begin
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end else if (imem_ready) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a   <= gpr[rs];
                    b   <= gpr[rt];
                    ext <= (op == OP_ORI) ? {16'h0000, imm} : {{16{imm[15]}}, imm};
                    if (legal) begin
                        state <= S_EXEC;
                    end else if (HALT_ON_ILLEGAL) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_EXEC: begin
                    alu <= alu_res;
                    if (op == OP_LW || op == OP_SW) begin
                        state      <= S_MEM;
                        dmem_req   <= 1'b1;
                        dmem_we    <= (op == OP_SW);
                        dmem_addr  <= {alu_res[31:2], 2'b00};
                        dmem_wdata <= (op == OP_SW) ? b : '0;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_req && dmem_ready) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        mdr      <= dmem_rdata;
                        if (op == OP_LW) state <= S_WB;
                    end
                end
                S_WB: begin
                    // illegal instructions reach here only as NOPs
                    if (legal) begin
                        if (wb_dst != 5'd0) gpr[wb_dst] <= wb_val;
                        wb_we   <= 1'b1;
                        wb_addr <= wb_dst;
                        wb_data <= wb_val;
                    end
                end
                S_HALT: begin
                    imem_req <= 1'b0;
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                    halted   <= 1'b1;
                end
                default: state <= S_HALT;
            endcase
            if (done) begin
                state     <= S_FETCH;
                pc        <= next_pc;
                imem_req  <= 1'b1;
                imem_addr <= next_pc;
                retire    <= 1'b1;
                retire_pc <= pc;
            end
        end
    end

endmodule
